// File: rtl/des_keysched.sv
// DES key schedule: PC1 load, per-round C/D rotation and PC2 compression.
// Issues K1..K16 (encrypt) or K16..K1 (decrypt) under a next/valid handshake.
module des_keysched (
   input  logic        hclk,
   input  logic        hreset,
   input  logic [63:0] q1_all,
   input  logic [63:0] q2_all,
   input  logic [63:0] q3_all,
   input  logic [1:0]  key_sel,
   input  logic        decrypt,
   input  logic        start,
   input  logic        next,
   output logic [47:0] subkey,
   output logic        subkey_vld,
   output logic [3:0]  round_cnt,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic {IDLE, RUN} state_t;

   // FIPS tables hold 1-based bit numbers with bit 1 at the MSB.
   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   state_t      state;
   state_t      state_next;
   logic [27:0] c_reg;
   logic [27:0] d_reg;
   logic        direction;
   logic [63:0] key;
   logic [55:0] pc1_cd;
   logic [55:0] cd;
   logic [4:0]  shift_idx;
   logic        shift_two;
   logic        load;
   logic        advance;
   logic        done_set;
   logic        err_set;

   function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
      return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
      return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
   endfunction

   always_comb begin
      case (key_sel)
         2'd0:    key = q1_all;
         2'd1:    key = q2_all;
         default: key = q3_all;
      endcase
   end

   always_comb begin
      pc1_cd = '0;
      for (int j = 0; j < 56; j++) begin
         pc1_cd[6'(55 - j)] = key[6'(64 - PC1_TBL[j])];
      end
   end

   assign cd = {c_reg, d_reg};

   always_comb begin
      subkey = '0;
      for (int j = 0; j < 48; j++) begin
         subkey[6'(47 - j)] = cd[6'(56 - PC2_TBL[j])];
      end
   end

   // Schedule index of the rotation that produces the next subkey to issue.
   always_comb begin
      shift_idx = direction ? (5'd16 - {1'b0, round_cnt}) : ({1'b0, round_cnt} + 5'd2);
      shift_two = !((shift_idx == 5'd1) || (shift_idx == 5'd2) ||
                    (shift_idx == 5'd9) || (shift_idx == 5'd16));
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      advance    = 1'b0;
      done_set   = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (key_sel == 2'd3) begin
                  err_set = 1'b1;
               end else begin
                  load       = 1'b1;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (next) begin
               if (round_cnt == 4'd15) begin
                  state_next = IDLE;
                  done_set   = 1'b1;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Encrypt loads C1/D1 so K1 is ready at once; decrypt loads C0/D0, which equals C16/D16.
   always_ff @(posedge hclk) begin
      if (hreset) begin
         c_reg     <= '0;
         d_reg     <= '0;
         round_cnt <= '0;
         direction <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= done_set;
         err  <= err_set;
         if (load) begin
            direction <= decrypt;
            round_cnt <= '0;
            if (decrypt) begin
               c_reg <= pc1_cd[55:28];
               d_reg <= pc1_cd[27:0];
            end else begin
               c_reg <= rotl(pc1_cd[55:28], 1'b0);
               d_reg <= rotl(pc1_cd[27:0], 1'b0);
            end
         end else if (advance) begin
            round_cnt <= round_cnt + 4'd1;
            if (direction) begin
               c_reg <= rotr(c_reg, shift_two);
               d_reg <= rotr(d_reg, shift_two);
            end else begin
               c_reg <= rotl(c_reg, shift_two);
               d_reg <= rotl(d_reg, shift_two);
            end
         end
      end
   end

   assign subkey_vld = (state == RUN);
   assign busy       = (state == RUN);

endmodule

// File: tb/tb_des_keysched.sv
// Directed bench for des_keysched using the classic 0x133457799BBCDFF1 key
// and its published subkeys K1..K16.
module tb_des_keysched;

   logic        hclk = 1'b0;
   logic        hreset;
   logic [63:0] q1_all;
   logic [63:0] q2_all;
   logic [63:0] q3_all;
   logic [1:0]  key_sel;
   logic        decrypt;
   logic        start;
   logic        next;
   logic [47:0] subkey;
   logic        subkey_vld;
   logic [3:0]  round_cnt;
   logic        busy;
   logic        done;
   logic        err;

   int check_count = 0;
   int fail_count  = 0;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_P = 64'h123457799BBCDFF0;

   logic [47:0] k_exp [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   des_keysched dut (
      .hclk       (hclk),
      .hreset     (hreset),
      .q1_all     (q1_all),
      .q2_all     (q2_all),
      .q3_all     (q3_all),
      .key_sel    (key_sel),
      .decrypt    (decrypt),
      .start      (start),
      .next       (next),
      .subkey     (subkey),
      .subkey_vld (subkey_vld),
      .round_cnt  (round_cnt),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 hclk = ~hclk;

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] sel, input logic dec, input logic nxt);
      key_sel = sel;
      decrypt = dec;
      next    = nxt;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Walks a full schedule with next held high, starting at round 0.
   task automatic runChecks(input logic dec, input string tag);
      for (int r = 0; r < 16; r++) begin
         checkOutput($sformatf("%s_key%0d", tag, r), {16'h0, subkey}, {16'h0, dec ? k_exp[15-r] : k_exp[r]});
         checkOutput($sformatf("%s_cnt%0d", tag, r), {60'h0, round_cnt}, r);
         checkOutput($sformatf("%s_vld%0d", tag, r), {63'h0, subkey_vld}, 64'd1);
         tick();
      end
      checkOutput({tag, "_done"}, {63'h0, done}, 64'd1);
      checkOutput({tag, "_busy_end"}, {63'h0, busy}, 64'd0);
      checkOutput({tag, "_vld_end"}, {63'h0, subkey_vld}, 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      hreset  = 1'b1;
      q1_all  = '0;
      q2_all  = '0;
      q3_all  = '0;
      key_sel = '0;
      decrypt = 1'b0;
      start   = 1'b0;
      next    = 1'b0;
      tick();
      tick();
      checkOutput("rst_subkey", {16'h0, subkey}, 64'd0);
      checkOutput("rst_vld", {63'h0, subkey_vld}, 64'd0);
      checkOutput("rst_busy", {63'h0, busy}, 64'd0);
      checkOutput("rst_done", {63'h0, done}, 64'd0);
      checkOutput("rst_err", {63'h0, err}, 64'd0);
      checkOutput("rst_cnt", {60'h0, round_cnt}, 64'd0);
      hreset = 1'b0;
      tick();

      $display("[TB] encrypt schedule on q1");
      q1_all = KEY_A;
      applyStimulus(2'd0, 1'b0, 1'b1);
      runChecks(1'b0, "enc");
      next = 1'b0;
      tick();
      checkOutput("enc_done_once", {63'h0, done}, 64'd0);

      $display("[TB] parity-only key on q3, q1/q2 garbage");
      q1_all = 64'hFFFF_FFFF_FFFF_FFFF;
      q2_all = 64'hA5A5_5A5A_0F0F_F0F0;
      q3_all = KEY_P;
      applyStimulus(2'd2, 1'b0, 1'b1);
      q3_all = 64'h0;
      q1_all = 64'h0;
      runChecks(1'b0, "par");
      next = 1'b0;
      tick();

      $display("[TB] handshake with next every third cycle");
      q1_all = KEY_A;
      q2_all = 64'hDEAD_BEEF_0123_4567;
      applyStimulus(2'd0, 1'b0, 1'b0);
      for (int r = 0; r < 16; r++) begin
         checkOutput($sformatf("hs_key%0d", r), {16'h0, subkey}, {16'h0, k_exp[r]});
         checkOutput($sformatf("hs_cnt%0d", r), {60'h0, round_cnt}, r);
         if (r == 5) begin
            start   = 1'b1;
            decrypt = 1'b1;
            key_sel = 2'd1;
         end
         tick();
         start = 1'b0;
         checkOutput($sformatf("hs_hold%0d", r), {16'h0, subkey}, {16'h0, k_exp[r]});
         checkOutput($sformatf("hs_busy%0d", r), {63'h0, busy}, 64'd1);
         tick();
         checkOutput($sformatf("hs_hold2_%0d", r), {16'h0, subkey}, {16'h0, k_exp[r]});
         next = 1'b1;
         tick();
         next = 1'b0;
      end
      checkOutput("hs_done", {63'h0, done}, 64'd1);
      tick();
      checkOutput("hs_done_once", {63'h0, done}, 64'd0);

      $display("[TB] illegal key_sel and idle next");
      key_sel = 2'd3;
      start   = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("err_pulse", {63'h0, err}, 64'd1);
      checkOutput("err_busy", {63'h0, busy}, 64'd0);
      checkOutput("err_vld", {63'h0, subkey_vld}, 64'd0);
      checkOutput("err_cd_kept", {16'h0, subkey}, {16'h0, k_exp[15]});
      next = 1'b1;
      tick();
      checkOutput("err_single", {63'h0, err}, 64'd0);
      tick();
      checkOutput("idle_next_cnt", {60'h0, round_cnt}, 64'd15);
      checkOutput("idle_next_key", {16'h0, subkey}, {16'h0, k_exp[15]});
      checkOutput("idle_next_busy", {63'h0, busy}, 64'd0);

      $display("[TB] reset abort at round 7");
      applyStimulus(2'd0, 1'b0, 1'b1);
      for (int r = 0; r < 7; r++) begin
         tick();
      end
      checkOutput("abort_cnt_pre", {60'h0, round_cnt}, 64'd7);
      hreset = 1'b1;
      tick();
      hreset = 1'b0;
      checkOutput("abort_vld", {63'h0, subkey_vld}, 64'd0);
      checkOutput("abort_busy", {63'h0, busy}, 64'd0);
      checkOutput("abort_cnt", {60'h0, round_cnt}, 64'd0);
      checkOutput("abort_done", {63'h0, done}, 64'd0);
      checkOutput("abort_key", {16'h0, subkey}, 64'd0);
      tick();
      checkOutput("abort_no_done", {63'h0, done}, 64'd0);

      hreset  = 1'b1;
      key_sel = 2'd0;
      start   = 1'b1;
      tick();
      hreset = 1'b0;
      start  = 1'b0;
      checkOutput("rst_wins_busy", {63'h0, busy}, 64'd0);
      checkOutput("rst_wins_key", {16'h0, subkey}, 64'd0);

      $display("[TB] restart then back-to-back decrypt");
      applyStimulus(2'd0, 1'b0, 1'b1);
      runChecks(1'b0, "rst_enc");
      key_sel = 2'd0;
      decrypt = 1'b1;
      start   = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("b2b_busy", {63'h0, busy}, 64'd1);
      runChecks(1'b1, "dec");
      next = 1'b0;
      tick();
      checkOutput("dec_done_once", {63'h0, done}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
